// File: rtl/cs_frame_ctrl.sv
// cs_frame_ctrl: sequencing controller for the CS window-filter core.
// Buffers upstream samples in a FIFO, resets and primes the core, feeds one
// frame of samples and flags which core outputs carry a full window.
// Optional build macro: CS_FRAME_CTRL_PRIME_EN -- on entry to FEED with an
// empty window, popping waits until the FIFO holds min(WIN, rem) samples so
// that a slow producer does not cause an underrun at the start of a segment.
module cs_frame_ctrl #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CORE_LAT     = 1,
    parameter int unsigned CORE_RST_CYC = 2,
    parameter int unsigned WIN          = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] frame_len,
    input  logic [7:0]  in_x,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        core_reset,
    output logic [7:0]  core_x,
    input  logic [9:0]  core_y,
    output logic [9:0]  out_y,
    output logic        out_valid,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned X_W     = 8;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned WIN_W   = $clog2(WIN + 1);
    localparam int unsigned CYC_MAX = (CORE_RST_CYC > CORE_LAT + 1) ? CORE_RST_CYC : CORE_LAT + 1;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRST,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Sample FIFO
    logic [X_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [X_W-1:0]   fifo_head;

    // Frame bookkeeping
    logic [LEN_W-1:0] rem;
    logic [WIN_W-1:0] win_cnt;
    logic [CYC_W-1:0] cyc_cnt;
    logic [CORE_LAT:0] tag_pipe;

    // Handshake and control strobes
    logic push;
    logic pop;
    logic starve;
    logic hold;
    logic tag_in;

    // Next-state values for every register
    logic [CNT_W-1:0] count_nxt;
    logic [LEN_W-1:0] rem_nxt;
    logic [WIN_W-1:0] win_cnt_nxt;
    logic [WIN_W-1:0] win_inc;
    logic [CYC_W-1:0] cyc_cnt_nxt;
    logic [X_W-1:0]   core_x_nxt;
    logic             underrun_nxt;
    logic             in_ready_nxt;
    logic             core_reset_nxt;
    logic             busy_nxt;
    logic             done_nxt;

`ifdef CS_FRAME_CTRL_PRIME_EN
    // Priming threshold; a FIFO shallower than the window could never meet WIN
    function automatic logic [LEN_W-1:0] prime_thresh(input logic [LEN_W-1:0] r);
        logic [LEN_W-1:0] t;
        t = (DEPTH < WIN) ? LEN_W'(DEPTH) : LEN_W'(WIN);
        return (r < t) ? r : t;
    endfunction
`endif

    assign fifo_head = mem[rd_ptr];
    assign push      = in_valid & in_ready;

    // Pop / underrun decision for the current FEED cycle
    always_comb begin
        hold = 1'b0;
`ifdef CS_FRAME_CTRL_PRIME_EN
        hold = (state == ST_FEED) && (win_cnt == '0) &&
               (LEN_W'(count) < prime_thresh(rem));
`endif
        pop    = (state == ST_FEED) && (count != '0) && !hold;
        starve = (state == ST_FEED) && (count == '0) && !hold;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (frame_len == '0) ? ST_DONE : ST_CRST;
                end
            end
            ST_CRST: begin
                if (cyc_cnt == CYC_W'(CORE_RST_CYC - 1)) begin
                    state_nxt = ST_FEED;
                end
            end
            ST_FEED: begin
                if (pop && (rem == LEN_W'(1))) begin
                    state_nxt = ST_DRAIN;
                end else if (starve) begin
                    state_nxt = ST_CRST;
                end
            end
            ST_DRAIN: begin
                if (cyc_cnt == CYC_W'(CORE_LAT)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values, registered below so outputs track state
    always_comb begin
        count_nxt    = count + CNT_W'(push) - CNT_W'(pop);
        rem_nxt      = rem;
        win_cnt_nxt  = win_cnt;
        cyc_cnt_nxt  = '0;
        core_x_nxt   = core_x;
        underrun_nxt = underrun;
        tag_in       = 1'b0;
        win_inc      = (win_cnt == WIN_W'(WIN)) ? win_cnt : win_cnt + WIN_W'(1);

        if ((state_nxt == state) && ((state == ST_CRST) || (state == ST_DRAIN))) begin
            cyc_cnt_nxt = cyc_cnt + CYC_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    rem_nxt      = frame_len;
                    underrun_nxt = 1'b0;
                end
            end
            ST_CRST: begin
                win_cnt_nxt = '0;
            end
            ST_FEED: begin
                if (pop) begin
                    core_x_nxt  = fifo_head;
                    rem_nxt     = rem - LEN_W'(1);
                    win_cnt_nxt = win_inc;
                    tag_in      = (win_inc == WIN_W'(WIN));
                end else if (starve) begin
                    underrun_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase

        in_ready_nxt   = (count_nxt != CNT_W'(DEPTH));
        busy_nxt       = (state_nxt != ST_IDLE);
        done_nxt       = (state_nxt == ST_DONE);
        core_reset_nxt = (state_nxt != ST_FEED) && (state_nxt != ST_DRAIN);
`ifdef CS_FRAME_CTRL_PRIME_EN
        // Keep the core in reset while the window is still being gathered
        if ((state_nxt == ST_FEED) && (win_cnt_nxt == '0) &&
            (LEN_W'(count_nxt) < prime_thresh(rem_nxt))) begin
            core_reset_nxt = 1'b1;
        end
`endif
    end

    // Control, counter and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rem        <= '0;
            win_cnt    <= '0;
            cyc_cnt    <= '0;
            tag_pipe   <= '0;
            in_ready   <= 1'b1;
            core_reset <= 1'b1;
            core_x     <= '0;
            out_y      <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count      <= count_nxt;
            rem        <= rem_nxt;
            win_cnt    <= win_cnt_nxt;
            cyc_cnt    <= cyc_cnt_nxt;
            tag_pipe   <= {tag_pipe[CORE_LAT-1:0], tag_in};
            in_ready   <= in_ready_nxt;
            core_reset <= core_reset_nxt;
            core_x     <= core_x_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            underrun   <= underrun_nxt;
            // Tag stage output lines up with the core_y of the tagged sample
            out_valid  <= tag_pipe[CORE_LAT];
            if (tag_pipe[CORE_LAT]) begin
                out_y <= core_y;
            end
        end
    end

    // FIFO storage; contents are don't-care once the pointers are cleared
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_x;
        end
    end

endmodule

// File: doc/cs_frame_ctrl.md
Name: cs_frame_ctrl

Overview:
- Sequencing controller for the CS window-filter core.
- The CS core (ports Y[9:0], X[7:0], active-high reset, clk) consumes one X every clock and has no enable. Its output is meaningful only once 9 consecutive samples have been fed.
- This block buffers upstream samples in a FIFO, resets and primes the core, feeds one frame of samples, and flags which core outputs are valid.
- It detects input underrun and recovers by re-priming the core window.

Parameters:
- DEPTH, 16: sample FIFO depth, power of 2, minimum 4.
- CORE_LAT, 1: clock edges from a sample appearing on core_x to the corresponding core_y being stable.
- CORE_RST_CYC, 2: number of cycles core_reset is held in state CRST.
- WIN, 9: window length; out_valid is asserted from the WIN-th consecutive fed sample onward.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-low.
- start  in  1  one-cycle pulse; honoured only in IDLE.
- frame_len  in  16  number of samples in the frame; sampled on start.
- in_x  in  8  upstream sample.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  FIFO not full (registered).
- core_reset  out  1  active-high reset to the CS core.
- core_x  out  8  registered sample to core X.
- core_y  in  10  core Y.
- out_y  out  10  registered filtered result.
- out_valid  out  1  out_y valid this cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at frame end.
- underrun  out  1  sticky; cleared on accepted start.

Behaviour:
- Reset (reset=0 at posedge):
  - State goes to IDLE and the FIFO is flushed.
  - in_ready=1, core_reset=1, core_x=0, out_y=0, out_valid=0, busy=0, done=0, underrun=0.
  - The tag pipeline and all counters are cleared. This applies at any time, including mid-frame.
- FIFO:
  - A push occurs when in_valid & in_ready, in any state.
  - in_ready is computed from the registered occupancy. A push into a full FIFO is refused even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full FIFO leaves occupancy unchanged.
- States:
  - IDLE:
    - core_reset=1.
    - On start with frame_len=0: go to DONE.
    - On start with frame_len≠0: latch rem=frame_len, clear underrun, go to CRST.
  - CRST:
    - core_reset=1 for CORE_RST_CYC cycles; win_cnt=0; then go to FEED.
  - FEED:
    - core_reset=0.
    - If the FIFO is non-empty:
      - pop; core_x<=head; rem--.
      - win_cnt increments, saturating at WIN.
      - tag_in = 1 when the post-increment win_cnt equals WIN, else 0.
      - If rem reaches 0, go to DRAIN.
    - If the FIFO is empty:
      - underrun<=1; core_x holds; tag_in=0.
      - go to CRST. rem is kept; the window restarts from 0.
  - DRAIN:
    - core_reset=0, tag_in=0.
    - Stay CORE_LAT+1 cycles so the last tags flush, then go to DONE.
  - DONE:
    - done=1 for one cycle, then go to IDLE.
- Output timing:
  - tag_in travels with core_x through a CORE_LAT-stage shift register.
  - When the stage output is 1: out_y<=core_y, out_valid<=1. Otherwise out_valid<=0 and out_y holds.
  - out_valid is therefore high CORE_LAT+1 cycles after the tagged sample appears on core_x.
- Valid count: frames (or post-underrun segments) shorter than WIN produce no out_valid. A segment of n≥WIN consecutive samples produces n−WIN+1 valid outputs.
- start outside IDLE is ignored.

Optional Feature:
- Macro: CS_FRAME_CTRL_PRIME_EN.
- Defined:
  - On entry to FEED with win_cnt=0, popping is held off until FIFO occupancy ≥ min(WIN, rem).
  - While waiting: core_reset stays 1, and an empty FIFO does not set underrun.
  - After the threshold is met, behaviour is as normal FEED.
- Undefined: FEED pops as soon as the FIFO is non-empty.

Test Plan:
- Preload 12 samples (0x10..0x1B), start with frame_len=12 → exactly 4 out_valid pulses carrying core_y for samples 9..12; done pulses once; busy falls with done; underrun=0.
- start with frame_len=0 → done pulses on the cycle after IDLE; core_reset never falls; out_valid never asserted.
- frame_len=20; supply 10 samples back-to-back, a 3-cycle gap, then 10 more (macro off) → underrun=1; core_reset reasserted for 2 cycles; total out_valid count = 2+2 = 4; done pulses once.
- Same stimulus with CS_FRAME_CTRL_PRIME_EN → underrun=0; 12 valid outputs.
- In IDLE, push 20 samples with in_valid held high → in_ready falls after the 16th accept; 4 samples are refused; in_ready returns to 1 after the first FEED pop.
- Assert reset=0 mid-FEED for 1 cycle → next cycle: state IDLE, FIFO empty, out_valid=0, core_reset=1, busy=0; a new start runs the frame cleanly.
